// File: rtl/mem_responder.sv
// Memory-side responder: services one read or write request at a time
// against an internal word-addressed RAM. Each request is followed by a
// programmable number of wait states, then a single-cycle Ack pulse.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ack,
  output logic              AddrErr,
  output logic              Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEPTH = 1 << MEM_AW;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic                addr_err_q, addr_err_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   read_data_q;

  logic                access_en;
  logic                addr_ok;
  logic [MEM_AW-1:0]   mem_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  // The range check and RAM index always use the latched address, so
  // anything the requester does to Addr during WAIT has no effect.
  assign addr_ok = (addr_q[ADDR_W-1:MEM_AW] == '0);
  assign mem_idx = addr_q[MEM_AW-1:0];

  // Next-state logic: capture in IDLE, count down in WAIT, access on the
  // cycle the counter reads zero, then a single DONE cycle carrying Ack.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = 1'b0;
    addr_err_d = 1'b0;
    access_en  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          wr_d    = MemWrite;
          addr_d  = Addr;
          wdata_d = WriteData;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access_en  = 1'b1;
          ack_d      = 1'b1;
          addr_err_d = ~addr_ok;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      addr_err_q <= addr_err_d;
      busy_q     <= busy_d;
    end
  end

  // RAM write port: only on the access edge, in range, and not under reset,
  // so a write aborted by reset never reaches the array.
  always_ff @(posedge CLK) begin
    if (!Reset && access_en && wr_q && addr_ok) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  // Registered read port: updated only by a completed read; out-of-range
  // reads return zero and writes leave the previous result in place.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      read_data_q <= '0;
    end else if (access_en && !wr_q) begin
      read_data_q <= addr_ok ? mem[mem_idx] : '0;
    end
  end

  assign ReadData = read_data_q;
  assign Ack      = ack_q;
  assign AddrErr  = addr_err_q;
  assign Busy     = busy_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle control unit's memory requests. It accepts one read or write request at a time over a Req/Ack handshake and services it against an internal word-addressed RAM after a configurable number of wait states. It returns registered read data and an address-error flag. It sits between the datapath's memory address/data muxes and the storage array and replaces the ideal zero-wait memory.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, processor address width (word addresses)
MEM_AW, 10, implemented RAM address bits; depth = 2^MEM_AW words
WAIT_CYCLES, 2, extra cycles between request capture and access; legal 0..15

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous reset, active-high
Req  input  1  request valid; requester holds it until it sees Ack
MemWrite  input  1  1 = write, 0 = read; sampled with Req
Addr  input  ADDR_W  word address; sampled with Req
WriteData  input  DATA_W  write data; sampled with Req
ReadData  output  DATA_W  registered read result; holds until the next read completes
Ack  output  1  one-cycle completion pulse
AddrErr  output  1  out-of-range flag; valid only while Ack=1, else 0
Busy  output  1  high whenever state != IDLE

Behaviour:
- One clock and a synchronous, active-high Reset. Reset is sampled on the CLK rising edge.
- Reset forces state=IDLE, ReadData=0, Ack=0, AddrErr=0, Busy=0, wait counter=0. RAM contents are not cleared.
- States are IDLE, WAIT and DONE. All outputs are registered.
- IDLE: on an edge with Req=1, latch MemWrite, Addr and WriteData, load cnt=WAIT_CYCLES, and go to WAIT. Busy=1 from the next cycle.
- WAIT, edge with cnt!=0: cnt decrements. Inputs are ignored; changes to Addr, WriteData or MemWrite have no effect.
- WAIT, edge with cnt==0: perform the access using the latched values, set Ack=1, go to DONE.
  - Write: RAM[addr] <= data.
  - Read: ReadData <= RAM[addr].
- DONE: Ack=1 for exactly this cycle. The next edge clears Ack and AddrErr and returns to IDLE.
- Timing: Ack is high during cycle WAIT_CYCLES+1 after the capture edge. Occupancy is WAIT_CYCLES+2 cycles per transaction.
- Requester rule: the requester must deassert Req in the Ack cycle. Req=1 seen in IDLE after DONE is a new request, so back-to-back transactions have no idle cycle.
- Req=1 while Busy is ignored; it is not queued.
- Range check: if latched Addr[ADDR_W-1:MEM_AW] != 0, AddrErr=1 together with Ack.
  - Write: the RAM is unchanged.
  - Read: ReadData <= 0.
- A write never changes ReadData.
- Reset mid-transaction (WAIT or DONE): abort, and go to IDLE with all outputs 0. A write whose access edge has not occurred is not performed; a completed write stays in RAM.
- Reset on the same edge as Req=1 in IDLE: reset wins and the request is not captured.
- The wait counter is 4 bits. WAIT_CYCLES=0 gives a single WAIT cycle, so Ack comes 1 cycle after the capture edge.
- RAM: a single port, synchronous write and registered read in the access edge only; no other read paths.

Test Plan:
1. WAIT_CYCLES=2, after reset: write 0x1234 to 0x0005, then read 0x0005 → each Ack is a single-cycle pulse exactly 3 cycles after the capture edge, Busy=1 for 4 cycles, read gives ReadData=0x1234 with AddrErr=0.
2. Back-to-back: write 0xAAAA to 0x0001, Req re-asserted in the cycle after Ack to read 0x0001 → no idle cycle between transactions, ReadData=0xAAAA; a further write of 0x5555 to 0x0002 leaves ReadData at 0xAAAA.
3. Out of range: write 0xBEEF to 0x8000 → AddrErr=1 only in the Ack cycle; read 0x8000 → ReadData=0x0000, AddrErr=1; read 0x0000 → its prior value unchanged.
4. Input corruption: capture a write of 0x00FF to 0x0003, then during WAIT drive Addr=0x0004, WriteData=0xFFFF, MemWrite=0 → read 0x0003 returns 0x00FF, read 0x0004 unchanged.
5. Reset in WAIT of a write of 0x7777 to 0x0010 (prior value 0x1111) → no Ack, Busy=0 the next cycle; subsequent read 0x0010 returns 0x1111. Reset asserted with Req in IDLE → no capture.
6. WAIT_CYCLES=0 instance: read 0x0005 after writing 0x0042 → Ack 1 cycle after capture, ReadData=0x0042; Req held high while Busy does not start a second transaction before DONE.
